// File: rtl/mc_maindec_hs_if.sv
// mc_maindec_hs_if: opcode/ready inputs and datapath control bundle of the multicycle main decoder.
interface mc_maindec_hs_if;
  logic [5:0] op;
  logic       mem_ready;
  logic       memreq, pcwrite, irwrite, regwrite, alusrca, branch, bne;
  logic       iord, memtoreg, regdst, dtype, illegal, memerr;
  logic [1:0] memwrite, pcsrc, ltype;
  logic [2:0] alusrcb, aluop;
  logic [4:0] stateshow;
  modport master (
    input  op, mem_ready,
    output memreq, pcwrite, irwrite, regwrite, alusrca, branch, bne, iord, memtoreg, regdst,
           dtype, illegal, memerr, memwrite, pcsrc, ltype, alusrcb, aluop, stateshow
  );
  modport slave (
    output op, mem_ready,
    input  memreq, pcwrite, irwrite, regwrite, alusrca, branch, bne, iord, memtoreg, regdst,
           dtype, illegal, memerr, memwrite, pcsrc, ltype, alusrcb, aluop, stateshow
  );
endinterface

// File: rtl/mc_maindec_hs.sv
// mc_maindec_hs: multicycle MIPS main controller with ready handshake, memory watchdog and XLEN-gated LD/SD.
// Build option MAINDEC_TRAP_EN: illegal opcodes lock the FSM in TRAP until reset.
module mc_maindec_hs #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16,
  parameter int CW      = 5
) (
  input logic clk,
  input logic reset,
  mc_maindec_hs_if.master bus
);
  localparam logic [3:0] S_IF = 4'd0, S_ID = 4'd1, S_EX_LS = 4'd2, S_MEM_LD = 4'd3, S_WB_L = 4'd4,
                         S_MEM_ST = 4'd5, S_EX_R = 4'd6, S_WB_R = 4'd7, S_EX_BR = 4'd8,
                         S_EX_J = 4'd9, S_EX_I = 4'd10, S_WB_I = 4'd11;
`ifdef MAINDEC_TRAP_EN
  localparam logic [3:0] S_TRAP = 4'd12;
  localparam logic [3:0] S_ILL  = S_TRAP;
`else
  localparam logic [3:0] S_ILL  = S_IF;
`endif
  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011, OP_LB = 6'b100000,
                         OP_LBU = 6'b100100, OP_SB = 6'b101000, OP_LD = 6'b110111, OP_SD = 6'b111111,
                         OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_J = 6'b000010, OP_ADDI = 6'b001000,
                         OP_ANDI = 6'b001100, OP_ORI = 6'b001101, OP_SLTI = 6'b001010;
  localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);

  logic [3:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          memerr_q, memerr_d;
  logic          ld64, sd64, is_ld, is_st, is_r, is_br, is_j, is_imm, waiting, expire;

  assign ld64   = (XLEN == 64) && (bus.op == OP_LD);
  assign sd64   = (XLEN == 64) && (bus.op == OP_SD);
  assign is_ld  = bus.op == OP_LW || bus.op == OP_LB || bus.op == OP_LBU || ld64;
  assign is_st  = bus.op == OP_SW || bus.op == OP_SB || sd64;
  assign is_r   = bus.op == OP_R;
  assign is_br  = bus.op == OP_BEQ || bus.op == OP_BNE;
  assign is_j   = bus.op == OP_J;
  assign is_imm = bus.op == OP_ADDI || bus.op == OP_ANDI || bus.op == OP_ORI || bus.op == OP_SLTI;
  assign waiting = state_q == S_IF || state_q == S_MEM_LD || state_q == S_MEM_ST;
  // a ready in the expiry cycle is a completion, so expiry needs ready low
  assign expire  = (TIMEOUT > 0) && waiting && !bus.mem_ready && cnt_q == T_LAST;

  assign bus.memerr    = memerr_q;
  assign bus.stateshow = {1'b0, state_q};

  always_comb begin
    bus.memreq   = 1'b0;
    bus.pcwrite  = 1'b0;
    bus.irwrite  = 1'b0;
    bus.regwrite = 1'b0;
    bus.alusrca  = 1'b0;
    bus.branch   = 1'b0;
    bus.bne      = 1'b0;
    bus.iord     = 1'b0;
    bus.memtoreg = 1'b0;
    bus.regdst   = 1'b0;
    bus.dtype    = 1'b0;
    bus.illegal  = 1'b0;
    bus.memwrite = 2'b00;
    bus.pcsrc    = 2'b00;
    bus.ltype    = 2'b00;
    bus.alusrcb  = 3'b000;
    bus.aluop    = 3'b000;
    state_d      = state_q;
    case (state_q)
      S_IF: begin
        bus.memreq  = 1'b1;
        bus.alusrcb = 3'b001;
        bus.irwrite = bus.mem_ready;
        bus.pcwrite = bus.mem_ready;
        state_d     = bus.mem_ready ? S_ID : S_IF;
      end
      S_ID: begin
        bus.alusrcb = 3'b011;
        bus.illegal = !(is_ld || is_st || is_r || is_br || is_j || is_imm);
        state_d     = (is_ld || is_st) ? S_EX_LS : is_r ? S_EX_R : is_br ? S_EX_BR :
                      is_j ? S_EX_J : is_imm ? S_EX_I : S_ILL;
      end
      S_EX_LS: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 3'b010;
        state_d     = is_ld ? S_MEM_LD : S_MEM_ST;
      end
      S_MEM_LD: begin
        bus.iord   = 1'b1;
        bus.memreq = 1'b1;
        bus.ltype  = bus.op == OP_LB ? 2'b10 : bus.op == OP_LBU ? 2'b01 : 2'b00;
        bus.dtype  = ld64;
        state_d    = bus.mem_ready ? S_WB_L : S_MEM_LD;
      end
      S_WB_L: begin
        bus.regwrite = 1'b1;
        bus.memtoreg = 1'b1;
        state_d      = S_IF;
      end
      S_MEM_ST: begin
        bus.iord     = 1'b1;
        bus.memreq   = 1'b1;
        bus.memwrite = !bus.mem_ready ? 2'b00 : bus.op == OP_SW ? 2'b01 :
                       bus.op == OP_SB ? 2'b10 : sd64 ? 2'b11 : 2'b00;
        state_d      = bus.mem_ready ? S_IF : S_MEM_ST;
      end
      S_EX_R: begin
        bus.alusrca = 1'b1;
        bus.aluop   = 3'b010;
        state_d     = S_WB_R;
      end
      S_WB_R: begin
        bus.regwrite = 1'b1;
        bus.regdst   = 1'b1;
        state_d      = S_IF;
      end
      S_EX_BR: begin
        bus.alusrca = 1'b1;
        bus.aluop   = 3'b001;
        bus.pcsrc   = 2'b01;
        bus.branch  = bus.op == OP_BEQ;
        bus.bne     = bus.op == OP_BNE;
        state_d     = S_IF;
      end
      S_EX_J: begin
        bus.pcwrite = 1'b1;
        bus.pcsrc   = 2'b10;
        state_d     = S_IF;
      end
      S_EX_I: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = (bus.op == OP_ANDI || bus.op == OP_ORI) ? 3'b100 : 3'b010;
        bus.aluop   = bus.op == OP_ANDI ? 3'b011 : bus.op == OP_ORI ? 3'b100 :
                      bus.op == OP_SLTI ? 3'b101 : 3'b000;
        state_d     = S_WB_I;
      end
      S_WB_I: begin
        bus.regwrite = 1'b1;
        state_d      = S_IF;
      end
`ifdef MAINDEC_TRAP_EN
      S_TRAP: bus.illegal = 1'b1;
`endif
      default: state_d = S_IF;
    endcase
    if (expire) state_d = S_IF;
  end

  assign memerr_d = memerr_q | expire;
  assign cnt_d    = (expire || state_d != state_q) ? '0 :
                    (waiting && !bus.mem_ready) ? cnt_q + 1'b1 : cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IF;
      cnt_q    <= '0;
      memerr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      memerr_q <= memerr_d;
    end
  end
endmodule

// File: tb/tb_mc_maindec_hs.sv
// tb_mc_maindec_hs: directed vector table plus randomized run against an instruction-level reference model.
module tb_mc_maindec_hs;
  localparam logic [5:0] RT = 6'h00, LW = 6'h23, SW = 6'h2b, LB = 6'h20, LBU = 6'h24, SB = 6'h28,
                         LD = 6'h37, SD = 6'h3f, BEQ = 6'h04, BNE = 6'h05, JJ = 6'h02, ADDI = 6'h08,
                         ANDI = 6'h0c, ORI = 6'h0d, SLTI = 6'h0a;
`ifdef MAINDEC_TRAP_EN
  localparam int ILL_ST = 12;
`else
  localparam int ILL_ST = 0;
`endif

  typedef struct {
    logic [5:0]  op;
    logic        rdy;
    logic [16:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mc_maindec_hs_if i32();
  mc_maindec_hs_if i64();
  mc_maindec_hs #(.XLEN(32), .TIMEOUT(4), .CW(3)) u32 (.clk(clk), .reset(reset), .bus(i32.master));
  mc_maindec_hs #(.XLEN(64), .TIMEOUT(0), .CW(5)) u64 (.clk(clk), .reset(reset), .bus(i64.master));

  logic [29:0] o32, o64;
  logic [16:0] obs;
  assign o32 = {i32.memreq, i32.pcwrite, i32.memwrite, i32.irwrite, i32.regwrite, i32.alusrca, i32.branch,
                i32.bne, i32.iord, i32.memtoreg, i32.regdst, i32.alusrcb, i32.pcsrc, i32.aluop, i32.ltype,
                i32.dtype, i32.illegal, i32.memerr, i32.stateshow};
  assign o64 = {i64.memreq, i64.pcwrite, i64.memwrite, i64.irwrite, i64.regwrite, i64.alusrca, i64.branch,
                i64.bne, i64.iord, i64.memtoreg, i64.regdst, i64.alusrcb, i64.pcsrc, i64.aluop, i64.ltype,
                i64.dtype, i64.illegal, i64.memerr, i64.stateshow};
  assign obs = {i32.stateshow, i32.irwrite, i32.regwrite, i32.memwrite, i32.illegal, i32.aluop, i32.pcsrc,
                i32.branch, i32.bne};

  int checks = 0, errors = 0;
  int mst[2], wcnt[2], pos[2], len[2], seq[2][4];
  logic merr[2];
  logic [5:0] opv[2];
  logic rdyv[2];
  logic [5:0] ops[17] = '{LW, LB, LBU, SW, SB, LD, SD, RT, BEQ, BNE, JJ, ADDI, ANDI, ORI, SLTI, 6'h3e, 6'h01};
  vec_t tbl[17];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [16:0] mk(int st, logic irw, logic rw, logic [1:0] mw, logic ill,
                                     logic [2:0] aop, logic [1:0] pcs, logic br, logic bn);
    return {5'(st), irw, rw, mw, ill, aop, pcs, br, bn};
  endfunction

  function automatic bit legal(logic [5:0] o, bit x64);
    return o == RT || o == LW || o == SW || o == LB || o == LBU || o == SB || o == BEQ || o == BNE ||
           o == JJ || o == ADDI || o == ANDI || o == ORI || o == SLTI || (x64 && (o == LD || o == SD));
  endfunction

  // expected control bundle, field by field, as a function of the current state
  function automatic logic [29:0] expo(int st, logic [5:0] o, logic r, bit x64, logic me);
    logic mr, pcw, irw, rw, asa, br, bn, io, m2r, rd, dt, ill;
    logic [1:0] mw, pcs, lt;
    logic [2:0] asb, aop;
    mr  = st == 0 || st == 3 || st == 5;
    irw = st == 0 && r;
    pcw = irw || st == 9;
    mw  = (st == 5 && r) ? (o == SW ? 2'b01 : o == SB ? 2'b10 : (x64 && o == SD) ? 2'b11 : 2'b00) : 2'b00;
    rw  = st == 4 || st == 7 || st == 11;
    asa = st == 2 || st == 6 || st == 8 || st == 10;
    br  = st == 8 && o == BEQ;
    bn  = st == 8 && o == BNE;
    io  = st == 3 || st == 5;
    m2r = st == 4;
    rd  = st == 7;
    asb = st == 0 ? 3'b001 : st == 1 ? 3'b011 : st == 2 ? 3'b010 :
          st == 10 ? ((o == ANDI || o == ORI) ? 3'b100 : 3'b010) : 3'b000;
    pcs = st == 8 ? 2'b01 : st == 9 ? 2'b10 : 2'b00;
    aop = st == 6 ? 3'b010 : st == 8 ? 3'b001 :
          st == 10 ? (o == ANDI ? 3'b011 : o == ORI ? 3'b100 : o == SLTI ? 3'b101 : 3'b000) : 3'b000;
    lt  = st == 3 ? (o == LB ? 2'b10 : o == LBU ? 2'b01 : 2'b00) : 2'b00;
    dt  = st == 3 && x64 && o == LD;
    ill = st == 12 || (st == 1 && !legal(o, x64));
    return {mr, pcw, mw, irw, rw, asa, br, bn, io, m2r, rd, asb, pcs, aop, lt, dt, ill, me, 5'(st)};
  endfunction

  // instruction-level model: ID expands the opcode into its list of remaining states
  task automatic step(int i, int xlen, int tmo);
    bit x64 = (xlen == 64);
    logic [5:0] o = opv[i];
    if ((mst[i] == 0 || mst[i] == 3 || mst[i] == 5) && !rdyv[i]) begin
      wcnt[i]++;
      if (tmo > 0 && wcnt[i] == tmo) begin
        merr[i] = 1'b1;
        mst[i]  = 0;
        wcnt[i] = 0;
      end
      return;
    end
    wcnt[i] = 0;
    if (mst[i] == 12) return;
    if (mst[i] == 0) begin
      mst[i] = 1;
      return;
    end
    if (mst[i] == 1) begin
      pos[i] = 0;
      len[i] = 0;
      if (o == LW || o == LB || o == LBU || (x64 && o == LD)) begin
        seq[i][0] = 2; seq[i][1] = 3; seq[i][2] = 4; len[i] = 3;
      end else if (o == SW || o == SB || (x64 && o == SD)) begin
        seq[i][0] = 2; seq[i][1] = 5; len[i] = 2;
      end else if (o == RT) begin
        seq[i][0] = 6; seq[i][1] = 7; len[i] = 2;
      end else if (o == BEQ || o == BNE) begin
        seq[i][0] = 8; len[i] = 1;
      end else if (o == JJ) begin
        seq[i][0] = 9; len[i] = 1;
      end else if (o == ADDI || o == ANDI || o == ORI || o == SLTI) begin
        seq[i][0] = 10; seq[i][1] = 11; len[i] = 2;
      end
    end
    if (pos[i] < len[i]) begin
      mst[i] = seq[i][pos[i]];
      pos[i]++;
    end else mst[i] = (mst[i] == 1) ? ILL_ST : 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mst[i] = 0; wcnt[i] = 0; pos[i] = 0; len[i] = 0; merr[i] = 1'b0;
    end
  endtask

  task automatic apply(logic [5:0] o, logic r);
    i32.op = o;
    i32.mem_ready = r;
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pct;
    tbl[0]  = '{LW, 1'b1, mk(0, 1'b1, 1'b0, 2'b00, 1'b0, 3'b000, 2'b00, 1'b0, 1'b0)};
    tbl[1]  = '{LW, 1'b1, mk(1, 1'b0, 1'b0, 2'b00, 1'b0, 3'b000, 2'b00, 1'b0, 1'b0)};
    tbl[2]  = '{LW, 1'b1, mk(2, 1'b0, 1'b0, 2'b00, 1'b0, 3'b000, 2'b00, 1'b0, 1'b0)};
    tbl[3]  = '{LW, 1'b1, mk(3, 1'b0, 1'b0, 2'b00, 1'b0, 3'b000, 2'b00, 1'b0, 1'b0)};
    tbl[4]  = '{LW, 1'b1, mk(4, 1'b0, 1'b1, 2'b00, 1'b0, 3'b000, 2'b00, 1'b0, 1'b0)};
    tbl[5]  = '{SB, 1'b1, mk(0, 1'b1, 1'b0, 2'b00, 1'b0, 3'b000, 2'b00, 1'b0, 1'b0)};
    tbl[6]  = '{SB, 1'b1, mk(1, 1'b0, 1'b0, 2'b00, 1'b0, 3'b000, 2'b00, 1'b0, 1'b0)};
    tbl[7]  = '{SB, 1'b1, mk(2, 1'b0, 1'b0, 2'b00, 1'b0, 3'b000, 2'b00, 1'b0, 1'b0)};
    tbl[8]  = '{SB, 1'b0, mk(5, 1'b0, 1'b0, 2'b00, 1'b0, 3'b000, 2'b00, 1'b0, 1'b0)};
    tbl[9]  = '{SB, 1'b0, mk(5, 1'b0, 1'b0, 2'b00, 1'b0, 3'b000, 2'b00, 1'b0, 1'b0)};
    tbl[10] = '{SB, 1'b0, mk(5, 1'b0, 1'b0, 2'b00, 1'b0, 3'b000, 2'b00, 1'b0, 1'b0)};
    tbl[11] = '{SB, 1'b1, mk(5, 1'b0, 1'b0, 2'b10, 1'b0, 3'b000, 2'b00, 1'b0, 1'b0)};
    tbl[12] = '{BNE, 1'b1, mk(0, 1'b1, 1'b0, 2'b00, 1'b0, 3'b000, 2'b00, 1'b0, 1'b0)};
    tbl[13] = '{BNE, 1'b1, mk(1, 1'b0, 1'b0, 2'b00, 1'b0, 3'b000, 2'b00, 1'b0, 1'b0)};
    tbl[14] = '{BNE, 1'b1, mk(8, 1'b0, 1'b0, 2'b00, 1'b0, 3'b001, 2'b01, 1'b0, 1'b1)};
    tbl[15] = '{LD, 1'b1, mk(0, 1'b1, 1'b0, 2'b00, 1'b0, 3'b000, 2'b00, 1'b0, 1'b0)};
    tbl[16] = '{LD, 1'b1, mk(1, 1'b0, 1'b0, 2'b00, 1'b1, 3'b000, 2'b00, 1'b0, 1'b0)};
    reset = 1'b1;
    i32.op = LW; i32.mem_ready = 1'b0;
    i64.op = JJ; i64.mem_ready = 1'b1;
    #1 chk("reset_state", 32'(o32), 32'(expo(0, LW, 1'b0, 1'b0, 1'b0)));
    do_reset();
    for (int k = 0; k < 17; k++) begin
      apply(tbl[k].op, tbl[k].rdy);
      chk($sformatf("vec%0d", k), 32'(obs), 32'(tbl[k].exp));
      adv();
    end
`ifdef MAINDEC_TRAP_EN
    for (int k = 0; k < 10; k++) begin
      apply(LD, 1'b1);
      chk("trap_hold", 32'({i32.stateshow, i32.illegal, i32.memreq, i32.irwrite}), 32'({5'd12, 3'b100}));
      adv();
    end
`else
    apply(LD, 1'b0);
    chk("illegal_skip", 32'({i32.stateshow, i32.illegal}), 32'({5'd0, 1'b0}));
    adv();
`endif
    do_reset();
    for (int k = 0; k < 4; k++) begin
      apply(LW, 1'b0);
      chk("wd_wait", 32'({i32.memerr, i32.irwrite, i32.stateshow}), 32'({2'b00, 5'd0}));
      adv();
    end
    for (int k = 0; k < 3; k++) begin
      apply(LW, 1'b0);
      chk("wd_sticky", 32'({i32.memerr, i32.irwrite}), 32'(2'b10));
      adv();
    end
    apply(LW, 1'b1);
    chk("wd_ready", 32'({i32.memerr, i32.irwrite}), 32'(2'b11));
    adv();
    do_reset();
    apply(LW, 1'b0);
    chk("wd_cleared", 32'(i32.memerr), 32'(0));
    adv();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      apply(SW, 1'b1);
      adv();
    end
    apply(SW, 1'b1);
    chk("st_strobe", 32'({i32.stateshow, i32.memwrite}), 32'({5'd5, 2'b01}));
    #1 reset = 1'b1;
    #1 chk("st_reset", 32'({i32.stateshow, i32.memwrite}), 32'({5'd0, 2'b00}));
    for (int b = 0; b < 10; b++) begin
      do_reset();
      pct = (b % 2 == 1) ? 50 : 85;
      for (int c = 0; c < 150; c++) begin
        for (int i = 0; i < 2; i++) begin
          if (mst[i] == 0 && $urandom_range(0, 1) == 1) opv[i] = ops[$urandom_range(0, 16)];
          rdyv[i] = $urandom_range(0, 99) < pct;
        end
        i32.op = opv[0]; i32.mem_ready = rdyv[0];
        i64.op = opv[1]; i64.mem_ready = rdyv[1];
        @(negedge clk);
        chk("rand_x32", 32'(o32), 32'(expo(mst[0], opv[0], rdyv[0], 1'b0, merr[0])));
        chk("rand_x64", 32'(o64), 32'(expo(mst[1], opv[1], rdyv[1], 1'b1, merr[1])));
        step(0, 32, 4);
        step(1, 64, 0);
        adv();
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    opv[0] = LW; opv[1] = LW;
  end
endmodule
